// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit address bus and transceiver output-enable.
// Each tenure is bounded by a hold timer, and consecutive owners are separated by one dead cycle.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  localparam int OW      = $clog2(NREQ),
  localparam int CW      = $clog2(MAX_HOLD) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      done,
  input  logic [16*NREQ-1:0]   addr_in,
  input  logic [NREQ-1:0]      oe_in,
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic                 owner_valid,
  output logic                 timeout,
  output logic [15:0]          Direcciones,
  output logic                 oe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_hold_cnt, w_hold_cnt;
  logic [OW-1:0]   r_last_owner, w_last_owner;
  logic [NREQ-1:0] w_gnt;
  logic [OW-1:0]   w_owner;
  logic            w_owner_valid;
  logic            w_timeout;

  logic [OW-1:0]   w_win;
  logic [OW-1:0]   w_cand;
  logic            w_found;
  logic            w_own_done;
  logic            w_own_drop;
  logic            w_hold_max;

  // Search starts just after the last owner, so it only wins again when nobody else asks.
  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = OW'((int'(r_last_owner) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_own_done = done[owner];
  assign w_own_drop = ~req[owner];
  assign w_hold_max = (r_hold_cnt == CW'(MAX_HOLD - 1));

  always_comb begin
    w_state       = r_state;
    w_hold_cnt    = r_hold_cnt;
    w_last_owner  = r_last_owner;
    w_gnt         = gnt;
    w_owner       = owner;
    w_owner_valid = owner_valid;
    w_timeout     = 1'b0;
    case (r_state)
      IDLE, RELEASE: begin
        w_gnt         = '0;
        w_owner_valid = 1'b0;
        w_state       = IDLE;
        if (w_found) begin
          w_state       = GRANT;
          w_gnt         = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_owner       = w_win;
          w_owner_valid = 1'b1;
          w_hold_cnt    = '0;
        end
      end
      GRANT: begin
        w_hold_cnt = r_hold_cnt + CW'(1);
        if (w_own_done || w_own_drop || w_hold_max) begin
          // A voluntary release on the same edge as expiry is not a timeout.
          w_state       = RELEASE;
          w_gnt         = '0;
          w_owner_valid = 1'b0;
          w_last_owner  = owner;
          w_timeout     = w_hold_max & ~w_own_done & ~w_own_drop;
        end
      end
      default: begin
        w_state       = IDLE;
        w_gnt         = '0;
        w_owner_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_last_owner <= OW'(NREQ - 1);
      gnt          <= '0;
      owner        <= '0;
      owner_valid  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold_cnt   <= w_hold_cnt;
      r_last_owner <= w_last_owner;
      gnt          <= w_gnt;
      owner        <= w_owner;
      owner_valid  <= w_owner_valid;
      timeout      <= w_timeout;
    end
  end

  always_comb begin
    Direcciones = 16'h0000;
    oe          = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_valid && owner == OW'(i)) begin
        Direcciones = addr_in[16*i +: 16];
        oe          = oe_in[i];
      end
    end
  end

endmodule
